// File: rtl/video_port_bank.sv
// Bank of 8-bit video control registers with shadow/active copies and a
// per-register update class (immediate, line start, frame start), plus the VINT line counter.
module video_port_bank #(
    parameter int                NREG       = 32,
    parameter int                AW         = 5,
    parameter logic [NREG-1:0]   LINE_MASK  = {NREG{1'b0}},
    parameter logic [NREG-1:0]   FRAME_MASK = {NREG{1'b0}},
    parameter logic [NREG*8-1:0] RESET_VAL  = {NREG*8{1'b0}},
    parameter logic [AW-1:0]     VINTL_ADDR = AW'(30),
    parameter logic [AW-1:0]     VINTH_ADDR = AW'(31),
    parameter int                LINES      = 320
) (
    input  logic              clk,
    input  logic              res,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [7:0]        d,
    input  logic              line_start_s,
    input  logic              frame_start,
    input  logic              int_start,
    input  logic              hold,
    output logic [NREG*8-1:0] regs,
    output logic [NREG-1:0]   pend,
    output logic [8:0]        vint_beg,
    output logic [3:0]        vint_inc
);

    localparam logic [AW:0] NREG_W  = (AW+1)'(NREG);
    localparam logic [9:0]  LINES_W = 10'(LINES);

    // Writes beyond the populated bank are dropped everywhere, VINT included.
    logic wr_hit;
    assign wr_hit = wr_en && ({1'b0, wr_addr} < NREG_W);

    logic line_go;
    logic frame_go;
    assign line_go  = line_start_s && !hold;
    assign frame_go = frame_start  && !hold;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            localparam bit IS_FRAME = FRAME_MASK[gi];
            localparam bit IS_LINE  = LINE_MASK[gi] && !FRAME_MASK[gi];
            localparam bit IS_IMM   = !IS_FRAME && !IS_LINE;

            logic [7:0] shadow_q, shadow_d;
            logic [7:0] active_q, active_d;
            logic       pend_q, pend_d;
            logic       sel;
            logic       boundary;

            assign sel      = wr_hit && (wr_addr == AW'(gi));
            assign boundary = IS_FRAME ? frame_go : (IS_LINE ? line_go : 1'b0);

            always_comb begin
                shadow_d = sel ? d : shadow_q;
                active_d = active_q;
                pend_d   = pend_q;
                if (IS_IMM) begin
                    if (sel) begin
                        active_d = d;
                    end
                end else if (boundary) begin
                    // shadow_d already carries a same-cycle write, so it latches directly.
                    active_d = shadow_d;
                    pend_d   = 1'b0;
                end else if (sel) begin
                    pend_d = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (res) begin
                    shadow_q <= RESET_VAL[8*gi +: 8];
                    active_q <= RESET_VAL[8*gi +: 8];
                    pend_q   <= 1'b0;
                end else begin
                    shadow_q <= shadow_d;
                    active_q <= active_d;
                    pend_q   <= pend_d;
                end
            end

            assign regs[8*gi +: 8] = active_q;
            assign pend[gi]        = pend_q;
        end
    endgenerate

    logic [8:0] vint_beg_q, vint_beg_d;
    logic [3:0] vint_inc_q, vint_inc_d;
    logic       vintl_wr;
    logic       vinth_wr;
    logic [9:0] vint_sum;

    assign vintl_wr = wr_hit && (wr_addr == VINTL_ADDR);
    assign vinth_wr = wr_hit && (wr_addr == VINTH_ADDR);
    assign vint_sum = {1'b0, vint_beg_q} + {6'b0, vint_inc_q};

    always_comb begin
        vint_beg_d = vint_beg_q;
        vint_inc_d = vint_inc_q;
        if (vintl_wr || vinth_wr) begin
            if (vintl_wr) begin
                vint_beg_d[7:0] = d;
            end
            if (vinth_wr) begin
                vint_beg_d[8] = d[0];
                vint_inc_d    = d[7:4];
            end
        end else if (int_start) begin
            // Values written above LINES are wrapped here by a single subtraction.
            vint_beg_d = (vint_sum >= LINES_W) ? 9'(vint_sum - LINES_W) : vint_sum[8:0];
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            vint_beg_q <= 9'd0;
            vint_inc_q <= 4'd0;
        end else begin
            vint_beg_q <= vint_beg_d;
            vint_inc_q <= vint_inc_d;
        end
    end

    assign vint_beg = vint_beg_q;
    assign vint_inc = vint_inc_q;

endmodule

// File: tb/tb_video_port_bank.sv
// Directed bench for video_port_bank: reset, immediate/line/frame classes, hold, VINT wrap, out-of-range writes.
module tb_video_port_bank;

    localparam int NREG = 24;
    localparam int AW   = 5;
    localparam int W    = NREG * 8;

    logic          clk = 1'b0;
    logic          res;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    d;
    logic          line_start_s;
    logic          frame_start;
    logic          int_start;
    logic          hold;
    logic [W-1:0]  regs;
    logic [NREG-1:0] pend;
    logic [8:0]    vint_beg;
    logic [3:0]    vint_inc;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_regs;

    video_port_bank #(
        .NREG      (NREG),
        .AW        (AW),
        .LINE_MASK (24'h000008),
        .FRAME_MASK(24'h000010),
        .RESET_VAL (192'h0500),
        .VINTL_ADDR(5'd20),
        .VINTH_ADDR(5'd21),
        .LINES     (320)
    ) dut (
        .clk         (clk),
        .res         (res),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .d           (d),
        .line_start_s(line_start_s),
        .frame_start (frame_start),
        .int_start   (int_start),
        .hold        (hold),
        .regs        (regs),
        .pend        (pend),
        .vint_beg    (vint_beg),
        .vint_inc    (vint_inc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        res = 0; wr_en = 0; wr_addr = '0; d = '0;
        line_start_s = 0; frame_start = 0; int_start = 0;
    endtask

    // Apply the current inputs across one rising edge, then return them to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wr(input int addr, input logic [7:0] val);
        wr_en = 1; wr_addr = AW'(addr); d = val;
    endtask

    function automatic logic [7:0] reg_of(input int i);
        return regs[8*i +: 8];
    endfunction

    initial begin
        idle();
        hold = 0;
        @(posedge clk); #1;

        // Reset pulsed during a write
        res = 1; wr(1, 8'hFF); tick();
        check("reset_reg1", W'(reg_of(1)), W'(8'h05));
        check("reset_regs", regs, W'(192'h0500));
        check("reset_pend", W'(pend), '0);
        check("reset_vint_beg", W'(vint_beg), '0);
        check("reset_vint_inc", W'(vint_inc), '0);

        // Immediate class
        wr(2, 8'hA5); tick();
        check("imm_reg2", W'(reg_of(2)), W'(8'hA5));
        check("imm_pend2", W'(pend[2]), '0);

        // Line class
        wr(3, 8'h3C); tick();
        check("line_wr_reg3", W'(reg_of(3)), '0);
        check("line_wr_pend3", W'(pend[3]), W'(1));
        line_start_s = 1; tick();
        check("line_latch_reg3", W'(reg_of(3)), W'(8'h3C));
        check("line_latch_pend3", W'(pend[3]), '0);
        wr(3, 8'h77); line_start_s = 1; tick();
        check("line_bypass_reg3", W'(reg_of(3)), W'(8'h77));
        check("line_bypass_pend3", W'(pend[3]), '0);

        // Hold across both boundaries
        hold = 1;
        wr(3, 8'h11); tick();
        wr(4, 8'h22); tick();
        line_start_s = 1; frame_start = 1; tick();
        check("hold_reg3", W'(reg_of(3)), W'(8'h77));
        check("hold_reg4", W'(reg_of(4)), '0);
        check("hold_pend", W'(pend), W'(24'h000018));
        wr(0, 8'h9A); tick();
        check("hold_imm_reg0", W'(reg_of(0)), W'(8'h9A));
        hold = 0;
        frame_start = 1; tick();
        check("frame_reg4", W'(reg_of(4)), W'(8'h22));
        check("frame_reg3_kept", W'(reg_of(3)), W'(8'h77));
        check("frame_pend", W'(pend), W'(24'h000008));
        line_start_s = 1; tick();
        check("line_after_hold_reg3", W'(reg_of(3)), W'(8'h11));
        check("line_after_hold_pend", W'(pend), '0);

        // VINT: 318 + 5 wraps to 3
        wr(20, 8'h3E); tick();
        wr(21, 8'h51); tick();
        check("vint_set_beg", W'(vint_beg), W'(318));
        check("vint_set_inc", W'(vint_inc), W'(5));
        check("vint_bank_reg20", W'(reg_of(20)), W'(8'h3E));
        int_start = 1; tick();
        check("vint_wrap", W'(vint_beg), W'(3));

        // inc=0 holds value
        wr(21, 8'h00); tick();
        wr(20, 8'd100); tick();
        int_start = 1; tick();
        check("vint_inc0", W'(vint_beg), W'(100));

        // Write beats increment in the same cycle
        wr(21, 8'h20); tick();
        wr(20, 8'h55); int_start = 1; tick();
        check("vint_wr_wins", W'(vint_beg), W'(85));
        int_start = 1; tick();
        check("vint_inc2", W'(vint_beg), W'(87));

        // Written value above LINES wraps on next increment
        wr(21, 8'h11); tick();
        check("vint_high", W'(vint_beg), W'(343));
        int_start = 1; tick();
        check("vint_high_wrap", W'(vint_beg), W'(24));

        // Out-of-range address
        exp_regs = '0;
        exp_regs[8*0 +: 8]  = 8'h9A;
        exp_regs[8*1 +: 8]  = 8'h05;
        exp_regs[8*2 +: 8]  = 8'hA5;
        exp_regs[8*3 +: 8]  = 8'h11;
        exp_regs[8*4 +: 8]  = 8'h22;
        exp_regs[8*20 +: 8] = 8'h55;
        exp_regs[8*21 +: 8] = 8'h11;
        check("pre_oor_regs", regs, exp_regs);
        wr(NREG, 8'hFF); tick();
        wr(NREG + 4, 8'hFF); tick();
        check("oor_regs", regs, exp_regs);
        check("oor_pend", W'(pend), '0);
        check("oor_vint_beg", W'(vint_beg), W'(24));
        check("oor_vint_inc", W'(vint_inc), W'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
